// File: rtl/timer_borrow_ctrl_if.sv
// Control/status bundle between the game logic, the head-of-chain timer
// controller and the BCD digit chain.
interface timer_borrow_ctrl_if;
  logic       arm;
  logic       defuse;
  logic       reconfig;
  logic       chain_zero;
  logic       borrow_down;
  logic [1:0] state;
  logic       expired;
  logic       defused;
  logic       tick;

  modport master (
    output arm, defuse, reconfig, chain_zero,
    input  borrow_down, state, expired, defused, tick
  );

  modport slave (
    input  arm, defuse, reconfig, chain_zero,
    output borrow_down, state, expired, defused, tick
  );
endinterface

// File: rtl/timer_borrow_ctrl.sv
// Head-of-chain countdown controller: a prescaler issues one-cycle borrow requests
// into the ONE digit and the FSM sequences IDLE/RUN/DEFUSED/EXPIRED.
module timer_borrow_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned CNT_W    = 27
) (
  input logic              clk,
  input logic              rst,
  timer_borrow_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_DEFUSED = 2'b10,
    S_EXPIRED = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             tick_q, tick_d;
  logic             term_cnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      tick_q   <= tick_d;
    end
  end

  assign term_cnt = (state_q == S_RUN) && (cnt_q == TC);

  // Next-state logic; reconfig overrides everything, expiry beats defuse.
  always_comb begin
    state_d = state_q;
    if (bus.reconfig) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.arm && !bus.chain_zero) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.chain_zero)  state_d = S_EXPIRED;
          else if (bus.defuse) state_d = S_DEFUSED;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Prescaler and pulse requests; the counter only advances while staying in RUN.
  always_comb begin
    cnt_d = '0;
    if ((state_q == S_RUN) && (state_d == S_RUN)) begin
      cnt_d = term_cnt ? '0 : cnt_q + CNT_W'(1);
    end
    tick_d   = term_cnt && !bus.reconfig;
    borrow_d = term_cnt && !bus.chain_zero && !bus.defuse && !bus.reconfig;
  end

  // Output logic: every output comes straight from a register.
  always_comb begin
    bus.state       = state_q;
    bus.borrow_down = borrow_q;
    bus.tick        = tick_q;
    bus.expired     = (state_q == S_EXPIRED);
    bus.defused     = (state_q == S_DEFUSED);
  end

endmodule

// File: tb/tb_timer_borrow_ctrl.sv
// Bench for timer_borrow_ctrl with a behavioural two-digit chain and a
// cycle-level reference model of the countdown rules.
module tb_timer_borrow_ctrl;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;

  timer_borrow_ctrl_if bus ();

  timer_borrow_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural digit chain: reload on reconfig, count down one per borrow.
  int dig_val  = 0;
  int load_val = 0;
  always @(posedge clk) begin
    if (bus.reconfig)                         dig_val <= load_val;
    else if (bus.borrow_down && dig_val > 0)  dig_val <= dig_val - 1;
  end
  assign bus.chain_zero = (dig_val == 0);

  // Reference model: mode 0 idle, 1 run, 2 defused, 3 expired; age = cycles since RUN entry.
  int   m_mode = 0;
  int   m_age  = 0;
  bit   m_bd, m_tick;
  logic [5:0] exp_q[$];

  typedef struct {
    bit         rc;
    bit         arm;
    bit         def;
    int         ld;
    logic [1:0] st;
    bit         bd;
    bit         tk;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit a, input bit d, input bit r, input bit cz);
    bit tc;
    tc     = (m_mode == 1) && ((m_age % TD) == TD - 1);
    m_tick = tc && !r;
    m_bd   = tc && !cz && !d && !r;
    if (r) m_mode = 0;
    else if (m_mode == 0) begin
      if (a && !cz) begin
        m_mode = 1;
        m_age  = 0;
      end
    end else if (m_mode == 1) begin
      if (cz)     m_mode = 3;
      else if (d) m_mode = 2;
      else        m_age++;
    end
    exp_q.push_back({m_mode[1:0], m_bd, m_tick, m_mode == 3, m_mode == 2});
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit a, input bit d, input bit r, input int ld);
    bit         cz;
    logic [5:0] act, e;
    bus.arm      = a;
    bus.defuse   = d;
    bus.reconfig = r;
    load_val     = ld;
    cz           = bus.chain_zero;
    @(posedge clk);
    model_step(a, d, r, cz);
    @(negedge clk);
    act = {bus.state, bus.borrow_down, bus.tick, bus.expired, bus.defused};
    e   = exp_q.pop_front();
    chk("model", act, e);
  endtask

  task automatic add_vec(input bit rc, input bit arm, input bit def, input int ld,
                         input logic [1:0] st, input bit bd, input bit tk);
    vec_t v;
    v.rc = rc; v.arm = arm; v.def = def; v.ld = ld;
    v.st = st; v.bd = bd; v.tk = tk;
    vq.push_back(v);
  endtask

  initial begin
    int npulse, exp_k, nbad;
    rst          = 1'b1;
    bus.arm      = 1'b0;
    bus.defuse   = 1'b0;
    bus.reconfig = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {bus.state, bus.borrow_down, bus.tick, bus.expired, bus.defused}, 6'd0);
    rst = 1'b0;

    // Directed table: zero-chain arm, countdown 2, reconfig+arm, defuse collisions.
    add_vec(1,0,0,0, 2'd0,0,0);  add_vec(0,1,0,0, 2'd0,0,0);
    add_vec(1,0,0,2, 2'd0,0,0);  add_vec(0,1,0,0, 2'd1,0,0);
    add_vec(0,0,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd1,0,0);
    add_vec(0,0,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd1,1,1);
    add_vec(0,1,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd1,0,0);
    add_vec(0,0,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd1,1,1);
    add_vec(0,0,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd3,0,0);
    add_vec(0,0,1,0, 2'd3,0,0);  add_vec(0,1,0,0, 2'd3,0,0);
    add_vec(1,1,0,2, 2'd0,0,0);  add_vec(0,1,0,0, 2'd1,0,0);
    add_vec(0,0,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd1,0,0);
    add_vec(0,0,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd1,1,1);
    add_vec(0,0,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd1,0,0);
    add_vec(0,0,0,0, 2'd1,0,0);  add_vec(0,0,1,0, 2'd2,0,1);
    add_vec(0,0,0,0, 2'd2,0,0);  add_vec(1,0,0,1, 2'd0,0,0);
    add_vec(0,1,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd1,0,0);
    add_vec(0,0,0,0, 2'd1,0,0);  add_vec(0,0,0,0, 2'd1,0,0);
    add_vec(0,0,0,0, 2'd1,1,1);  add_vec(0,0,0,0, 2'd1,0,0);
    add_vec(0,0,1,0, 2'd3,0,0);
    foreach (vq[i]) begin
      step(vq[i].arm, vq[i].def, vq[i].rc, vq[i].ld);
      chk("vec_state",   bus.state,       vq[i].st);
      chk("vec_borrow",  bus.borrow_down, vq[i].bd);
      chk("vec_tick",    bus.tick,        vq[i].tk);
      chk("vec_expired", bus.expired,     vq[i].st == 2'd3);
      chk("vec_defused", bus.defused,     vq[i].st == 2'd2);
    end

    // Full countdown from 12: pulses every TD cycles, expiry two cycles after the last.
    step(0,0,1,12);
    step(1,0,0,0);
    npulse = 0;
    exp_k  = -1;
    for (int k = 1; k <= 60; k++) begin
      step(0,0,0,0);
      if (bus.borrow_down) begin
        npulse++;
        chk("pulse_pos", k, TD * npulse);
      end
      if (bus.state == 2'd3 && exp_k < 0) exp_k = k;
    end
    chk("pulse_count", npulse, 12);
    chk("expire_cycle", exp_k, 50);
    chk("expired_lvl", bus.expired, 1'b1);

    // Defuse after the second pulse of a 05 countdown.
    step(0,0,1,5);
    step(1,0,0,0);
    npulse = 0;
    for (int k = 1; k <= 20 && npulse < 2; k++) begin
      step(0,0,0,0);
      if (bus.borrow_down) npulse++;
    end
    chk("def_pulses", npulse, 2);
    step(0,1,0,0);
    chk("def_state", bus.state, 2'd2);
    chk("def_digits", dig_val, 3);
    nbad = 0;
    for (int k = 0; k < 40; k++) begin
      step(0,0,0,0);
      if (bus.borrow_down || bus.tick) nbad++;
    end
    chk("def_quiet", nbad, 0);
    chk("def_hold", dig_val, 3);

    // Asynchronous reset mid-RUN with prescaler at 2, then 20 quiet IDLE cycles.
    step(0,0,1,12);
    step(1,0,0,0);
    step(0,0,0,0);
    step(0,0,0,0);
    rst = 1'b1;
    #1;
    chk("rst_async", {bus.state, bus.borrow_down, bus.tick, bus.expired, bus.defused}, 6'd0);
    @(negedge clk);
    rst    = 1'b0;
    m_mode = 0;
    m_age  = 0;
    exp_q.delete();
    nbad = 0;
    for (int k = 0; k < 20; k++) begin
      step(0,0,0,0);
      if (bus.borrow_down) nbad++;
    end
    chk("idle_no_borrow", nbad, 0);
    chk("idle_state", bus.state, 2'd0);
    chk("idle_digits", dig_val, 12);

    // Randomized traffic checked against the reference model.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0,5) == 0, $urandom_range(0,29) == 0,
           $urandom_range(0,39) == 0, $urandom_range(0,15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_borrow_ctrl.md
Name: timer_borrow_ctrl

Overview:
- Head-of-chain controller for the cascaded BCD countdown digits (ONE digit, then TEN digit).
- Generates the periodic one-cycle borrowDown request into the ONE digit from a clock prescaler.
- Consumes the chain-empty indication (noBorrowDown from the ONE digit) and sequences IDLE/RUN/DEFUSED/EXPIRED for the bomb game.
- Sits between the game FSM/buttons and the digit_timer_mod chain.

Parameters:
TICK_DIV, 100000000, clocks per countdown tick (1 s at 100 MHz); legal range >= 4; sims use 4
CNT_W, 27, prescaler width; must satisfy 2^CNT_W >= TICK_DIV

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
arm  in  1  one-cycle pulse, start countdown
defuse  in  1  one-cycle pulse, correct code entered
reconfig  in  1  one-cycle pulse, user reloads digits; also drives the digits' timerReconfig externally
chain_zero  in  1  noBorrowDown of the ONE digit; 1 = every digit in the chain reads 0
borrow_down  out  1  one-cycle borrow request to the ONE digit's borrowDown
state  out  2  00 IDLE, 01 RUN, 10 DEFUSED, 11 EXPIRED
expired  out  1  level, high while in EXPIRED
defused  out  1  level, high while in DEFUSED
tick  out  1  one-cycle pulse at every prescaler terminal count in RUN, including the expiring one

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, prescaler=0.
  - borrow_down=0, tick=0, expired=0, defused=0 immediately.
  - Release is synchronous to clk.
- All outputs are registered; no combinational input-to-output paths.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN, then wraps to 0.
  - Held at 0 in every other state.
  - Cleared on every entry to RUN.
- IDLE:
  - arm with chain_zero=0 -> RUN.
  - arm with chain_zero=1 is ignored (stays IDLE).
  - defuse is ignored.
- RUN:
  - At terminal count (prescaler==TICK_DIV-1), tick=1 on the next cycle.
  - If chain_zero=0 at that terminal count, borrow_down=1 on the next cycle, for exactly one cycle.
  - If chain_zero=1 at any RUN cycle, next state is EXPIRED and no borrow_down is issued.
  - defuse -> DEFUSED next cycle; prescaler freezes and borrow_down stays 0.
  - Simultaneous defuse and chain_zero=1: EXPIRED wins.
  - Simultaneous defuse and terminal count with chain_zero=0: DEFUSED wins, no borrow_down.
  - Repeated arm is ignored.
- DEFUSED / EXPIRED:
  - Terminal states; only reconfig or rst exits.
  - borrow_down=0.
- reconfig in any state: next state IDLE, prescaler=0, borrow_down=0.
  - reconfig has priority over arm, defuse and chain_zero in the same cycle.
- Latency:
  - First borrow_down occurs TICK_DIV cycles after the arm edge.
  - Subsequent borrow_down pulses are exactly TICK_DIV cycles apart.
- borrow_down timing:
  - Never asserted two consecutive cycles.
  - Never asserted outside RUN.
- chain_zero is registered by the digits and updates one cycle after borrow_down. TICK_DIV>=4 guarantees it is settled before the next terminal count.
- Countdown value N (TEN*10+ONE) reaches 00 after N borrows. EXPIRED is entered one cycle after chain_zero rises, independent of the prescaler.

Test Plan:
- Reset/idle: rst=1 mid-RUN (prescaler=2) -> all outputs 0 and state=00 in the same cycle; no borrow_down for 20 cycles while IDLE with the digits loaded to 12.
- Countdown to expiry (TICK_DIV=4, digits loaded 12, arm):
  - borrow_down pulses at cycles 4, 8, ..., 48 after arm (12 pulses); the ONE digit wraps 0->9 with a TEN borrow at pulse 3.
  - chain_zero rises after pulse 12, then state=11 and expired=1 one cycle later.
  - No 13th pulse.
- Defuse mid-count: arm with digits at 05, defuse after pulse 2 -> state=10, digits hold 03, no further borrow_down or tick for 40 cycles.
- Collisions:
  - defuse on the terminal-count cycle with chain_zero=0 -> DEFUSED, no borrow_down.
  - defuse in the same cycle chain_zero rises -> EXPIRED.
- Arm with zero chain: digits loaded 00, arm -> state stays 00 and borrow_down stays 0.
- Reconfig recovery: from EXPIRED, pulse reconfig with digits reloaded to 02, then arm -> RUN; first borrow_down 4 cycles after arm; EXPIRED after the 2nd pulse; reconfig coincident with arm -> IDLE.
